// File: rtl/lcm_pkg.sv
// Shared definitions for the LCM stage: FSM state encoding and default width.
package lcm_pkg;

    localparam int LCM_W = 16;

    typedef enum logic [1:0] {
        LS_IDLE = 2'd0,
        LS_DIV  = 2'd1,
        LS_MUL  = 2'd2,
        LS_DONE = 2'd3
    } lcm_state_e;

endpackage

// File: rtl/lcm_from_gcd_if.sv
// Operand/result bundle between the GCD write port, the LCM stage and the result collector.
interface lcm_from_gcd_if
    import lcm_pkg::*;
#(
    parameter int WIDTH = LCM_W
) ();

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     g;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   lcm;
    logic                 rem_nz;

    // Upstream side: presents operands and the start pulse, watches status/result.
    modport master (
        output start, a, b, g,
        input  busy, done, lcm, rem_nz
    );

    // LCM stage side.
    modport slave (
        input  start, a, b, g,
        output busy, done, lcm, rem_nz
    );

endinterface

// File: rtl/lcm_divstep_n.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only if it did not borrow.
module lcm_divstep_n
    import lcm_pkg::*;
#(
    parameter int WIDTH = LCM_W
) (
    input  logic [WIDTH-1:0] rem_in,   // previous remainder, always < g so WIDTH bits suffice
    input  logic             a_bit,
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH:0]   next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           bout;

    assign trial = {rem_in, a_bit};

    subripple_n #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .x    (trial),
        .y    ({1'b0, g}),
        .diff (diff),
        .bout (bout)
    );

    // No borrow means trial >= g: take the difference and emit a 1 quotient bit.
    assign q_bit    = ~bout;
    assign next_rem = bout ? trial : diff;

endmodule

// File: rtl/subripple_n.sv
// N-bit ripple-borrow subtractor: diff = x - y, bout set when x < y.
module subripple_n #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    logic [WIDTH:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign diff[i]       = x[i] ^ y[i] ^ borrow[i];
        assign borrow[i + 1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrow[i]);
    end

    assign bout = borrow[WIDTH];

endmodule

// File: rtl/lcm_from_gcd.sv
// LCM stage fed by the GCD block: lcm = (a / g) * b via a WIDTH-step restoring
// divider then a WIDTH-step shift-add multiplier, fixed 2*WIDTH-cycle latency.
module lcm_from_gcd
    import lcm_pkg::*;
#(
    parameter int WIDTH = LCM_W
) (
    input  logic          clk,
    input  logic          reset,   // asynchronous, active-low
    lcm_from_gcd_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    lcm_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // a_q shifts the dividend out MSB-first while quotient bits enter at the
    // LSB, so after DIV it holds q and MUL consumes it LSB-first.
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     g_q, g_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic                 zero_q, zero_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // b, shifted left one place per MUL step
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   lcm_q, lcm_d;
    logic                 rem_nz_q, rem_nz_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [WIDTH:0]       step_rem;
    logic                 step_q_bit;
    logic                 cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    lcm_divstep_n #(
        .WIDTH (WIDTH)
    ) u_divstep (
        .rem_in   (rem_q[WIDTH-1:0]),
        .a_bit    (a_q[WIDTH-1]),
        .g        (g_q),
        .next_rem (step_rem),
        .q_bit    (step_q_bit)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only matters in IDLE, each compute phase lasts WIDTH cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LS_IDLE: if (bus.start) state_d = LS_DIV;
            LS_DIV:  if (cnt_last)  state_d = LS_MUL;
            LS_MUL:  if (cnt_last)  state_d = LS_DONE;
            LS_DONE: state_d = LS_IDLE;
            default: state_d = LS_IDLE;
        endcase
    end

    // Datapath and output next values for each state.
    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        g_d      = g_q;
        rem_d    = rem_q;
        zero_d   = zero_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        lcm_d    = lcm_q;
        rem_nz_d = rem_nz_q;

        case (state_q)
            LS_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    g_d     = bus.g;
                    mcand_d = {{WIDTH{1'b0}}, bus.b};
                    zero_d  = (bus.a == '0) | (bus.b == '0) | (bus.g == '0);
                    rem_d   = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            LS_DIV: begin
                rem_d = step_rem;
                a_d   = {a_q[WIDTH-2:0], step_q_bit};
                cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
            end
            LS_MUL: begin
                acc_d   = acc_q + (a_q[0] ? mcand_q : '0);
                a_d     = a_q >> 1;
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                // Result registers load on the same edge that enters DONE.
                if (cnt_last) begin
                    lcm_d    = zero_q ? '0 : acc_d;
                    rem_nz_d = zero_q ? 1'b0 : (rem_q != '0);
                end
            end
            default: ;
        endcase
    end

    // Status outputs are registered copies of the upcoming state.
    always_comb begin
        busy_d = (state_d != LS_IDLE);
        done_d = (state_d == LS_DONE);
    end

    // Datapath and output registers, all cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            a_q      <= '0;
            g_q      <= '0;
            rem_q    <= '0;
            zero_q   <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            lcm_q    <= '0;
            rem_nz_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            g_q      <= g_d;
            rem_q    <= rem_d;
            zero_q   <= zero_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            lcm_q    <= lcm_d;
            rem_nz_q <= rem_nz_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.lcm    = lcm_q;
    assign bus.rem_nz = rem_nz_q;

endmodule

// File: tb/tb_lcm_from_gcd.sv
// Directed bench for lcm_from_gcd: latency, busy window, results, restart and abort.
module tb_lcm_from_gcd;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    lcm_from_gcd_if #(.WIDTH(16)) bus ();

    lcm_from_gcd #(
        .WIDTH (16)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, optionally re-pulse start at edges N+p1 / N+p2,
    // and check latency, busy window, result, hold and absence of a second job.
    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] g, input logic [31:0] exp_lcm,
                       input logic exp_rnz, input int p1, input int p2);
        logic [31:0] prev;
        int          lat;
        int          bcnt;
        bit          got;
        bit          early;
        prev  = bus.lcm;
        bus.a = a;
        bus.b = b;
        bus.g = g;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, ":busy_after_accept"}, 64'(bus.busy), 64'd1);
        check({tag, ":done_after_accept"}, 64'(bus.done), 64'd0);
        lat   = 0;
        bcnt  = 1;
        got   = 1'b0;
        early = 1'b0;
        while (!got && lat < 40) begin
            if (lat + 1 == p1 || lat + 1 == p2) begin
                bus.a = 16'd100;
                bus.b = 16'd3;
                bus.g = 16'd1;
                bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            lat++;
            if (bus.busy) bcnt++;
            if (bus.done) got = 1'b1;
            else if (bus.lcm !== prev) early = 1'b1;
        end
        check({tag, ":latency"}, 64'(lat), 64'd32);
        check({tag, ":lcm"}, 64'(bus.lcm), 64'(exp_lcm));
        check({tag, ":rem_nz"}, 64'(bus.rem_nz), 64'(exp_rnz));
        check({tag, ":busy_cycles"}, 64'(bcnt), 64'd33);
        check({tag, ":lcm_held_until_done"}, 64'(early), 64'd0);
        tick();
        check({tag, ":done_drop"}, 64'(bus.done), 64'd0);
        check({tag, ":busy_drop"}, 64'(bus.busy), 64'd0);
        check({tag, ":lcm_hold"}, 64'(bus.lcm), 64'(exp_lcm));
        tick();
        check({tag, ":no_second_job"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        bit seen_done;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.g     = '0;
        repeat (3) tick();
        check("reset:busy", 64'(bus.busy), 64'd0);
        check("reset:done", 64'(bus.done), 64'd0);
        check("reset:lcm", 64'(bus.lcm), 64'd0);
        check("reset:rem_nz", 64'(bus.rem_nz), 64'd0);
        rst_n = 1'b1;
        tick();

        run("basic_12_18_6", 16'd12, 16'd18, 16'd6, 32'd36, 1'b0, 0, 0);
        run("full_width", 16'd65535, 16'd65534, 16'd1, 32'd4294770690, 1'b0, 0, 0);
        run("zero_a", 16'd0, 16'd7, 16'd7, 32'd0, 1'b0, 0, 0);
        run("zero_g", 16'd5, 16'd9, 16'd0, 32'd0, 1'b0, 0, 0);
        run("inexact_10_4_3", 16'd10, 16'd4, 16'd3, 32'd12, 1'b1, 0, 0);
        run("inexact_7_5_2", 16'd7, 16'd5, 16'd2, 32'd15, 1'b1, 0, 0);
        run("max_equal", 16'd65535, 16'd65535, 16'd65535, 32'd65535, 1'b0, 0, 0);
        run("restart_ignored", 16'd4, 16'd6, 16'd2, 32'd12, 1'b0, 5, 32);

        // Abort an operation at cycle 20 with an asynchronous reset.
        bus.a = 16'd12;
        bus.b = 16'd18;
        bus.g = 16'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        check("abort:busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort:busy_in_reset", 64'(bus.busy), 64'd0);
        check("abort:done_in_reset", 64'(bus.done), 64'd0);
        check("abort:lcm_in_reset", 64'(bus.lcm), 64'd0);
        check("abort:rem_nz_in_reset", 64'(bus.rem_nz), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        check("abort:no_done_after", 64'(seen_done), 64'd0);
        check("abort:lcm_still_zero", 64'(bus.lcm), 64'd0);
        run("after_abort_21_6_3", 16'd21, 16'd6, 16'd3, 32'd42, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
